// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory port arbiter with a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed D priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ib_addr_i,
  input  logic        ib_valid_i,
  output logic [31:0] ib_data_o,
  output logic        ib_ready_o,
  input  logic [31:0] db_addr_i,
  input  logic [3:0]  db_lanes_i,
  input  logic [31:0] db_dout_i,
  input  logic        db_wr_i,
  input  logic        db_valid_i,
  output logic [31:0] db_din_o,
  output logic        db_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_lanes_o,
  output logic [31:0] mem_dout_o,
  output logic        mem_wr_o,
  output logic        mem_valid_o,
  input  logic [31:0] mem_din_i,
  input  logic        mem_ready_i,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic gnt_i, gnt_d, gnt_any;
  logic timeout_hit, done;

  assign gnt_i       = (state_q == S_GNT_I);
  assign gnt_d       = (state_q == S_GNT_D);
  assign gnt_any     = gnt_i | gnt_d;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TO_LAST));
  assign done        = mem_ready_i | timeout_hit;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_I;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/watchdog while granted
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (ib_valid_i && db_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = (last_grant_q == GRANT_I) ? S_GNT_D : S_GNT_I;
`else
          state_d = S_GNT_D;
`endif
        end else if (db_valid_i) begin
          state_d = S_GNT_D;
        end else if (ib_valid_i) begin
          state_d = S_GNT_I;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (done) begin
          state_d      = S_IDLE;
          last_grant_d = gnt_d ? GRANT_D : GRANT_I;
          wait_cnt_d   = '0;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: memory port muxed from the granted master, responses steered back
  always_comb begin
    mem_valid_o = gnt_any;
    mem_addr_o  = '0;
    mem_lanes_o = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    ib_ready_o  = 1'b0;
    ib_data_o   = '0;
    db_ready_o  = 1'b0;
    db_din_o    = '0;
    bus_err_o   = gnt_any && !mem_ready_i && timeout_hit;
    if (gnt_i) begin
      mem_addr_o  = ib_addr_i;
      mem_lanes_o = 4'b1111;
      ib_ready_o  = done && ib_valid_i;
      if (ib_ready_o && mem_ready_i) ib_data_o = mem_din_i;
    end
    if (gnt_d) begin
      mem_addr_o  = db_addr_i;
      mem_lanes_o = db_lanes_i;
      mem_dout_o  = db_dout_i;
      mem_wr_o    = db_wr_i;
      db_ready_o  = done && db_valid_i;
      if (db_ready_o && mem_ready_i) db_din_o = mem_din_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT overridden to 4).
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic [31:0] ib_addr, ib_data;
  logic        ib_valid, ib_ready;
  logic [31:0] db_addr, db_dout, db_din;
  logic [3:0]  db_lanes;
  logic        db_wr, db_valid, db_ready;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic [3:0]  mem_lanes;
  logic        mem_wr, mem_valid, mem_ready, bus_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ib_addr_i   (ib_addr),
    .ib_valid_i  (ib_valid),
    .ib_data_o   (ib_data),
    .ib_ready_o  (ib_ready),
    .db_addr_i   (db_addr),
    .db_lanes_i  (db_lanes),
    .db_dout_i   (db_dout),
    .db_wr_i     (db_wr),
    .db_valid_i  (db_valid),
    .db_din_o    (db_din),
    .db_ready_o  (db_ready),
    .mem_addr_o  (mem_addr),
    .mem_lanes_o (mem_lanes),
    .mem_dout_o  (mem_dout),
    .mem_wr_o    (mem_wr),
    .mem_valid_o (mem_valid),
    .mem_din_i   (mem_din),
    .mem_ready_i (mem_ready),
    .bus_err_o   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: observed timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic exp_d;
    rst_n = 1'b0; ib_addr = '0; ib_valid = 1'b0;
    db_addr = '0; db_lanes = '0; db_dout = '0; db_wr = 1'b0; db_valid = 1'b0;
    mem_din = '0; mem_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ready", {30'd0, ib_ready, db_ready}, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Fetch only, zero-wait; mem_ready in IDLE must be ignored
    next_cycle();
    ib_valid = 1'b1; ib_addr = 32'h100; mem_ready = 1'b1; mem_din = 32'h00000013;
    @(negedge clk);
    chk("t1_idle_valid", 32'(mem_valid), 32'd0);
    chk("t1_idle_ready", 32'(ib_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_lanes", 32'(mem_lanes), 32'hF);
    chk("t1_mem_wr", 32'(mem_wr), 32'd0);
    chk("t1_mem_dout", mem_dout, 32'd0);
    chk("t1_ib_ready", 32'(ib_ready), 32'd1);
    chk("t1_ib_data", ib_data, 32'h00000013);
    next_cycle();
    ib_valid = 1'b0; mem_ready = 1'b0; mem_din = '0;
    @(negedge clk);
    chk("t1_back_idle", 32'(mem_valid), 32'd0);
    chk("t1_data_zero", ib_data, 32'd0);

    // Byte-laned store
    next_cycle();
    db_valid = 1'b1; db_addr = 32'h2000; db_lanes = 4'b0011; db_dout = 32'h00213d05;
    db_wr = 1'b1; mem_ready = 1'b1; mem_din = 32'h12345678;
    next_cycle();
    @(negedge clk);
    chk("t2_mem_wr", 32'(mem_wr), 32'd1);
    chk("t2_mem_lanes", 32'(mem_lanes), 32'h3);
    chk("t2_mem_dout", mem_dout, 32'h00213d05);
    chk("t2_mem_addr", mem_addr, 32'h2000);
    chk("t2_db_ready", 32'(db_ready), 32'd1);
    chk("t2_ib_ready", 32'(ib_ready), 32'd0);
    next_cycle();
    db_valid = 1'b0; db_wr = 1'b0; db_lanes = 4'hF; mem_ready = 1'b0;
    @(negedge clk);
    chk("t2_no_repeat", 32'(db_ready), 32'd0);

    // Contention from a fresh reset: 8 zero-wait transfers
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    ib_valid = 1'b1; ib_addr = 32'h300; db_valid = 1'b1; db_addr = 32'h400;
    mem_ready = 1'b1; mem_din = 32'hA5A5A5A5;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("t3_idle_gap", 32'(mem_valid), 32'd0);
      next_cycle();
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = ((j % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      chk("t3_grant_addr", mem_addr, exp_d ? 32'h400 : 32'h300);
      chk("t3_db_ready", 32'(db_ready), 32'(exp_d));
      chk("t3_ib_ready", 32'(ib_ready), 32'(!exp_d));
      next_cycle();
    end
    ib_valid = 1'b0; db_valid = 1'b0; mem_ready = 1'b0;

    // Watchdog: memory never answers
    next_cycle();
    ib_valid = 1'b1; ib_addr = 32'h40; mem_din = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t4_idle", 32'(mem_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t4_mem_valid", 32'(mem_valid), 32'd1);
      chk("t4_bus_err", 32'(bus_err), 32'(k == 3));
      chk("t4_ib_ready", 32'(ib_ready), 32'(k == 3));
      chk("t4_ib_data", ib_data, 32'd0);
    end
    next_cycle();
    ib_valid = 1'b0;
    @(negedge clk);
    chk("t4_back_idle", 32'(mem_valid), 32'd0);
    chk("t4_err_pulse", 32'(bus_err), 32'd0);

    // Fetch flushed mid-grant, pending data request afterwards
    next_cycle();
    ib_valid = 1'b1; ib_addr = 32'h80; mem_din = 32'hCAFEF00D;
    next_cycle();
    @(negedge clk);
    chk("t5_gnt_addr", mem_addr, 32'h80);
    next_cycle();
    ib_valid = 1'b0; db_valid = 1'b1; db_addr = 32'h500; db_wr = 1'b0;
    @(negedge clk);
    chk("t5_held_addr", mem_addr, 32'h80);
    chk("t5_held_valid", 32'(mem_valid), 32'd1);
    next_cycle();
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_no_ib_ready", 32'(ib_ready), 32'd0);
    chk("t5_no_db_ready", 32'(db_ready), 32'd0);
    chk("t5_no_err", 32'(bus_err), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_idle_gap", 32'(mem_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_d_addr", mem_addr, 32'h500);
    chk("t5_d_ready", 32'(db_ready), 32'd1);
    chk("t5_d_data", db_din, 32'hCAFEF00D);

    // Reset asserted mid GNT_D
    next_cycle();
    mem_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t6_gnt", 32'(mem_valid), 32'd1);
    #1;
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(mem_valid), 32'd0);
    chk("t6_rst_ready", 32'(db_ready), 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    next_cycle();
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("t6_restart_idle", 32'(mem_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t6_regrant", 32'(mem_valid), 32'd1);
    chk("t6_regrant_addr", mem_addr, 32'h500);
    db_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
